// File: rtl/crypto_1506_pkg.sv
// Shared constants and types for the 1506-bit GF(p) cryptoprocessor.
package crypto_1506_pkg;

  localparam int W    = 1506;
  localparam int AW   = 7;
  localparam int NREG = 1 << AW;

  // Command word layout: {INS, rd_addr_1, rd_addr_2, wr_addr}
  localparam int INS_HI = 23;
  localparam int INS_LO = 21;
  localparam int RD1_HI = 20;
  localparam int RD1_LO = 14;
  localparam int RD2_HI = 13;
  localparam int RD2_LO = 7;
  localparam int WR_HI  = 6;
  localparam int WR_LO  = 0;

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_LOAD = 3'd1,
    OP_COPY = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_MUL  = 3'd5
  } op_t;

  localparam logic [W-1:0] P = 1506'd1658539334852043956605014686969369842243820155059458240864380460354175875596746126442552006529285980003318752448184629099761975446397870870332614114924526019655624366944770281974501212314250998405682106067115619475132937730960746637418716661215852316737808364060021400361715167852784987427099666051667608448888314571788638487985846716927693574019769274326804364407638203115258648742883949562283207610572974523311143132532016594886767069744238342663307263;

endpackage

// File: rtl/crypto_processor_wrapper_1506_fp_alu.sv
// Combinational GF(p) ALU: recombines each operand's shares, then
// performs a fully reduced add, subtract or multiply.
module fp_alu_1506
  import crypto_1506_pkg::*;
(
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] b1,
  input  logic [W-1:0] b2,
  input  op_t          op,
  output logic [W-1:0] res
);

  localparam logic [W:0]     P1 = {1'b0, P};
  localparam logic [2*W-1:0] P2 = {{W{1'b0}}, P};

  logic [W:0]     sa, sb;
  logic [W-1:0]   va, vb;
  logic [W:0]     sum, dif;
  logic [2*W-1:0] prod;

  // Share recombination: the raw share sum can exceed several multiples
  // of P, so reduce with a true modulus rather than a single subtract.
  assign sa = {1'b0, a1} + {1'b0, a2};
  assign sb = {1'b0, b1} + {1'b0, b2};
  assign va = W'(sa % P1);
  assign vb = W'(sb % P1);

  // Reduced operands keep add and subtract below 2P: one conditional subtract.
  assign sum  = {1'b0, va} + {1'b0, vb};
  assign dif  = {1'b0, va} + P1 - {1'b0, vb};
  assign prod = {{W{1'b0}}, va} * {{W{1'b0}}, vb};

  // Result select with final reduction into [0, P-1]
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = (sum >= P1) ? W'(sum - P1) : W'(sum);
      OP_SUB:  res = (dif >= P1) ? W'(dif - P1) : W'(dif);
      OP_MUL:  res = W'(prod % P2);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/crypto_processor_wrapper_1506.sv
// Share-based register file, command decode and output mux around the
// GF(p) ALU. One instruction per clock, read-before-write.
module crypto_processor_wrapper_1506
  import crypto_1506_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          get_output,
  input  logic          data_en,
  input  logic          ins_in,
  input  logic [23:0]   command_in,
  input  logic [W-1:0]  din_1,
  input  logic [W-1:0]  din_2,
  output logic [W-1:0]  dout_1,
  output logic [W-1:0]  dout_2
);

  logic [W-1:0] rf1 [NREG];
  logic [W-1:0] rf2 [NREG];

  op_t           op;
  logic [AW-1:0] rd1, rd2, wr;
  logic [W-1:0]  alu_res;
  logic          we;
  logic [W-1:0]  w1, w2;

  assign op  = op_t'(command_in[INS_HI:INS_LO]);
  assign rd1 = command_in[RD1_HI:RD1_LO];
  assign rd2 = command_in[RD2_HI:RD2_LO];
  assign wr  = command_in[WR_HI:WR_LO];

  fp_alu_1506 u_alu (
    .a1  (rf1[rd1]),
    .a2  (rf2[rd1]),
    .b1  (rf1[rd2]),
    .b2  (rf2[rd2]),
    .op  (op),
    .res (alu_res)
  );

  // Decode: pick write enable and the share pair to store
  always_comb begin
    we = 1'b0;
    w1 = '0;
    w2 = '0;
    if (ins_in) begin
      case (op)
        OP_LOAD: begin
          we = data_en;
          w1 = din_1;
          w2 = din_2;
        end
        OP_COPY: begin
          we = 1'b1;
          w1 = rf1[rd1];
          w2 = rf2[rd1];
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          we = 1'b1;
          w1 = alu_res;
          w2 = '0;
        end
        default: we = 1'b0;
      endcase
    end
  end

  // Register file: async clear of every entry, single write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf1[i] <= '0;
        rf2[i] <= '0;
      end
    end else if (we) begin
      rf1[wr] <= w1;
      rf2[wr] <= w2;
    end
  end

  assign dout_1 = get_output ? rf1[rd1] : '0;
  assign dout_2 = get_output ? rf2[rd1] : '0;

endmodule

// File: tb/tb_crypto_processor_wrapper_1506.sv
// Scoreboard bench: expected share pairs are queued when a read is
// issued and compared when dout is sampled on the falling edge.
module tb_crypto_processor_wrapper_1506;
  import crypto_1506_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          get_output;
  logic          data_en;
  logic          ins_in;
  logic [23:0]   command_in;
  logic [W-1:0]  din_1, din_2;
  logic [W-1:0]  dout_1, dout_2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*W-1:0] sb_q [$];
  string          tag_q [$];

  localparam logic [W-1:0] PM1 = P - W'(1);
  localparam logic [W-1:0] PM2 = P - W'(2);
  localparam logic [W-1:0] Z   = '0;

  crypto_processor_wrapper_1506 dut (
    .clk        (clk),
    .rst        (rst),
    .get_output (get_output),
    .data_en    (data_en),
    .ins_in     (ins_in),
    .command_in (command_in),
    .din_1      (din_1),
    .din_2      (din_2),
    .dout_1     (dout_1),
    .dout_2     (dout_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got s1=..%h s2=..%h want s1=..%h s2=..%h", tag,
               obs[W+63:W], obs[63:0], exp[W+63:W], exp[63:0]);
    end
  endtask

  // Issue one command, let it take effect at the next rising edge
  task automatic issue(input logic [2:0] ins, input logic [6:0] r1, input logic [6:0] r2,
                       input logic [6:0] wa, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input logic den, input logic iv);
    command_in = {ins, r1, r2, wa};
    din_1      = d1;
    din_2      = d2;
    data_en    = den;
    ins_in     = iv;
    get_output = 1'b0;
    @(posedge clk); #1;
    ins_in  = 1'b0;
    data_en = 1'b0;
  endtask

  task automatic ld(input logic [6:0] wa, input logic [W-1:0] d1, input logic [W-1:0] d2);
    issue(3'd1, 7'd0, 7'd0, wa, d1, d2, 1'b1, 1'b1);
  endtask

  task automatic op3(input logic [2:0] ins, input logic [6:0] r1, input logic [6:0] r2,
                     input logic [6:0] wa);
    issue(ins, r1, r2, wa, Z, Z, 1'b0, 1'b1);
  endtask

  // Queue the expectation, sample dout mid-cycle, pop and compare
  task automatic rd(input string tag, input logic [6:0] a, input logic ge,
                    input logic [W-1:0] e1, input logic [W-1:0] e2);
    logic [2*W-1:0] e;
    string t;
    command_in = {3'd0, a, 7'd0, 7'd0};
    ins_in     = 1'b0;
    get_output = ge;
    sb_q.push_back({e1, e2});
    tag_q.push_back(tag);
    @(negedge clk);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {dout_1, dout_2}, e);
    @(posedge clk); #1;
    get_output = 1'b0;
  endtask

  initial begin
    logic [W:0] s;
    logic [W:0] m;
    rst = 1'b0; get_output = 1'b0; data_en = 1'b0; ins_in = 1'b0;
    command_in = '0; din_1 = '0; din_2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    rd("reset_state", 7'd0, 1'b1, Z, Z);

    // Load / readback with unreduced shares
    ld(7'd9, PM1, W'(5));
    rd("load_rb", 7'd9, 1'b1, PM1, W'(5));
    command_in = {3'd0, 7'd9, 7'd0, 7'd0};
    get_output = 1'b1;
    @(negedge clk);
    s = {1'b0, dout_1} + {1'b0, dout_2};
    m = s % {1'b0, P};
    chk("load_val", {Z, m[W-1:0]}, {Z, W'(4)});
    @(posedge clk); #1;
    rd("gate_out", 7'd9, 1'b0, Z, Z);

    // Subtract wrap and add wrap
    ld(7'd0, W'(3), Z);
    ld(7'd1, W'(5), Z);
    op3(3'd4, 7'd0, 7'd1, 7'd2);
    rd("sub_wrap", 7'd2, 1'b1, PM2, Z);
    ld(7'd12, PM1, Z);
    ld(7'd13, W'(5), Z);
    op3(3'd3, 7'd12, 7'd13, 7'd14);
    rd("add_wrap", 7'd14, 1'b1, W'(4), Z);
    op3(3'd4, 7'd12, 7'd12, 7'd15);
    rd("sub_self", 7'd15, 1'b1, Z, Z);

    // x-only point doubling, back-to-back dependent instructions
    ld(7'd0, W'(5), Z);
    ld(7'd1, W'(3), Z);
    ld(7'd2, W'(8), Z);
    ld(7'd3, W'(4), Z);
    op3(3'd4, 7'd0, 7'd1, 7'd4);
    op3(3'd3, 7'd0, 7'd1, 7'd5);
    op3(3'd5, 7'd4, 7'd4, 7'd4);
    op3(3'd5, 7'd5, 7'd5, 7'd5);
    op3(3'd5, 7'd3, 7'd4, 7'd7);
    op3(3'd5, 7'd7, 7'd5, 7'd6);
    op3(3'd4, 7'd5, 7'd4, 7'd5);
    op3(3'd5, 7'd2, 7'd5, 7'd4);
    op3(3'd3, 7'd7, 7'd4, 7'd7);
    op3(3'd5, 7'd7, 7'd5, 7'd7);
    rd("dbl_x", 7'd6, 1'b1, W'(1024), Z);
    rd("dbl_z", 7'd7, 1'b1, W'(29760), Z);
    rd("dbl_t", 7'd5, 1'b1, W'(60), Z);

    // Copy and multiply boundary, including in-place aliasing
    op3(3'd2, 7'd9, 7'd0, 7'd20);
    rd("copy", 7'd20, 1'b1, PM1, W'(5));
    ld(7'd10, PM1, Z);
    op3(3'd5, 7'd10, 7'd10, 7'd11);
    rd("mul_pm1", 7'd11, 1'b1, W'(1), Z);
    op3(3'd5, 7'd10, 7'd10, 7'd10);
    rd("mul_inplace", 7'd10, 1'b1, W'(1), Z);

    // Read-before-write: dout shows old contents in the writing cycle
    command_in = {3'd1, 7'd9, 7'd0, 7'd9};
    din_1 = W'(77); din_2 = W'(88);
    data_en = 1'b1; ins_in = 1'b1; get_output = 1'b1;
    sb_q.push_back({PM1, W'(5)});
    tag_q.push_back("rbw_old");
    @(negedge clk);
    begin
      logic [2*W-1:0] e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {dout_1, dout_2}, e);
    end
    @(posedge clk); #1;
    ins_in = 1'b0; data_en = 1'b0; get_output = 1'b0;
    rd("rbw_new", 7'd9, 1'b1, W'(77), W'(88));

    // Gating: none of these may modify entry 40
    ld(7'd40, W'(7), W'(8));
    issue(3'd1, 7'd0, 7'd0, 7'd40, W'(1), W'(1), 1'b0, 1'b1);
    issue(3'd6, 7'd9, 7'd9, 7'd40, W'(1), W'(1), 1'b1, 1'b1);
    issue(3'd7, 7'd9, 7'd9, 7'd40, W'(1), W'(1), 1'b1, 1'b1);
    issue(3'd3, 7'd9, 7'd9, 7'd40, W'(1), W'(1), 1'b1, 1'b0);
    issue(3'd1, 7'd9, 7'd9, 7'd40, W'(1), W'(1), 1'b1, 1'b0);
    issue(3'd0, 7'd9, 7'd9, 7'd40, W'(1), W'(1), 1'b1, 1'b1);
    rd("gating", 7'd40, 1'b1, W'(7), W'(8));

    // Reset mid-sequence with a LOAD asserted during reset
    ld(7'd50, W'(11), W'(12));
    command_in = {3'd1, 7'd0, 7'd0, 7'd51};
    din_1 = W'(9); din_2 = W'(9);
    data_en = 1'b1; ins_in = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    ins_in = 1'b0; data_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rd("rst_50", 7'd50, 1'b1, Z, Z);
    rd("rst_51", 7'd51, 1'b1, Z, Z);
    rd("rst_9",  7'd9,  1'b1, Z, Z);
    rd("rst_40", 7'd40, 1'b1, Z, Z);
    rd("rst_7",  7'd7,  1'b1, Z, Z);

    // First instruction after reset release is accepted
    ld(7'd3, W'(21), W'(22));
    rd("post_rst", 7'd3, 1'b1, W'(21), W'(22));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
